// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core (master) and a responder (slave).
interface dmem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        byte_en;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req_valid, read, write, addr, wdata, byte_en, rsp_ready,
    input  req_ready, rsp_valid, rdata, err
  );

  modport slave (
    input  req_valid, read, write, addr, wdata, byte_en, rsp_ready,
    output req_ready, rsp_valid, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with byte-lane stores and an error flag.
// Latency: response valid WAIT_CYCLES+1 cycles after the request cycle.
// Backpressure: one request in flight; response held until rsp_ready, req_ready low meanwhile.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              req_ready_q, rsp_valid_q, err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              lat_read, lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_be;

  logic              c_read, c_write, c_err;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [3:0]        c_be;
  logic [ADDR_W-3:0] c_idx;
  logic              accept, enter_resp;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept     = bus.req_valid && req_ready_q;
  assign enter_resp = (state != S_RESP) && (state_nxt == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd1) state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the access commits on the accept edge, so use the live request.
  always_comb begin
    c_read  = lat_read;
    c_write = lat_write;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    c_be    = lat_be;
    if (state == S_IDLE) begin
      c_read  = bus.read;
      c_write = bus.write;
      c_addr  = bus.addr;
      c_wdata = bus.wdata;
      c_be    = bus.byte_en;
    end
  end

  assign c_err = (c_read == c_write) || (c_addr[1:0] != 2'b00);
  assign c_idx = c_addr[ADDR_W-1:2];

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_read  <= bus.read;
      lat_write <= bus.write;
      lat_addr  <= bus.addr;
      lat_wdata <= bus.wdata;
      lat_be    <= bus.byte_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      cnt         <= '0;
    end else begin
      req_ready_q <= (state_nxt == S_IDLE);
      if (accept)               cnt <= 4'(WAIT_CYCLES);
      else if (state == S_WAIT) cnt <= cnt - 4'd1;
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        err_q       <= c_err;
        rdata_q     <= (!c_err && c_read) ? mem[c_idx] : '0;
      end else if (rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        err_q       <= 1'b0;
      end
    end
  end

  // A store still waiting when reset hits never reaches the array.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && !c_err && c_write) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) share stimulus, one selected at a time.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid, read, write, rsp_ready;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [1:0]  sel;

  logic        m_req_ready, m_rsp_valid, m_err;
  logic [31:0] m_rdata;

  dmem_responder_if #(.DATA_W(32), .ADDR_W(10)) b0 ();
  dmem_responder_if #(.DATA_W(32), .ADDR_W(10)) b1 ();
  dmem_responder_if #(.DATA_W(32), .ADDR_W(10)) b3 ();

  dmem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst(rst), .bus(b0));
  dmem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst(rst), .bus(b1));
  dmem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .rst(rst), .bus(b3));

  assign b0.req_valid = req_valid && (sel == 2'd0);
  assign b0.read      = read;
  assign b0.write     = write;
  assign b0.addr      = addr;
  assign b0.wdata     = wdata;
  assign b0.byte_en   = byte_en;
  assign b0.rsp_ready = rsp_ready;
  assign b1.req_valid = req_valid && (sel == 2'd1);
  assign b1.read      = read;
  assign b1.write     = write;
  assign b1.addr      = addr;
  assign b1.wdata     = wdata;
  assign b1.byte_en   = byte_en;
  assign b1.rsp_ready = rsp_ready;
  assign b3.req_valid = req_valid && (sel == 2'd3);
  assign b3.read      = read;
  assign b3.write     = write;
  assign b3.addr      = addr;
  assign b3.wdata     = wdata;
  assign b3.byte_en   = byte_en;
  assign b3.rsp_ready = rsp_ready;

  always_comb begin
    m_req_ready = b1.req_ready;
    m_rsp_valid = b1.rsp_valid;
    m_rdata     = b1.rdata;
    m_err       = b1.err;
    if (sel == 2'd0) begin
      m_req_ready = b0.req_ready; m_rsp_valid = b0.rsp_valid; m_rdata = b0.rdata; m_err = b0.err;
    end else if (sel == 2'd3) begin
      m_req_ready = b3.req_ready; m_rsp_valid = b3.rsp_valid; m_rdata = b3.rdata; m_err = b3.err;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] xd;
    logic        xe;
  } vec_t;
  vec_t tbl[15];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no handshake want one within the cycle budget", name);
  endtask

  function automatic int wsel();
    return (sel == 2'd0) ? 0 : (sel == 2'd1) ? 1 : 3;
  endfunction

  // Latency is counted in cycles starting with the cycle the request is presented in.
  task automatic send(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] e, input logic [31:0] xd, input logic xe,
                      input int hold, input string tag, output int acc);
    int   n;
    int   lat;
    exp_t x;
    acc = 0;
    @(negedge clk);
    read = r; write = w; addr = a; wdata = d; byte_en = e; req_valid = 1'b1;
    rsp_ready = (hold == 0);
    n = 0;
    while (!m_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!m_req_ready) begin
      tmo({tag, " accept"});
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sbq.push_back('{xd, xe});
    #1;
    acc = cyc;
    req_valid = 1'b0;
    lat = 1;
    while (!m_rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!m_rsp_valid) begin
      tmo({tag, " response"});
      return;
    end
    x = sbq.pop_front();
    chk({tag, " latency"}, 32'(lat), 32'(wsel() + 1));
    chk({tag, " rdata"}, m_rdata, x.rdata);
    chk({tag, " err"}, 32'(m_err), 32'(x.err));
    for (int i = 0; i < hold; i++) begin
      read = 1'b0; write = 1'b1; addr = 10'h010; wdata = 32'h0; byte_en = 4'hF; req_valid = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, " hold rsp_valid"}, 32'(m_rsp_valid), 1);
      chk({tag, " hold rdata"}, m_rdata, x.rdata);
      chk({tag, " hold req_ready"}, 32'(m_req_ready), 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " done rsp_valid"}, 32'(m_rsp_valid), 0);
    chk({tag, " done req_ready"}, 32'(m_req_ready), 1);
    chk({tag, " done err"}, 32'(m_err), 0);
    chk({tag, " done rdata kept"}, m_rdata, x.rdata);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test want completion");
    $fatal(1);
  end

  initial begin
    int acc;
    int prev;
    int n;
    rst = 1'b1; req_valid = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    byte_en = '0; rsp_ready = 1'b1; sel = 2'd1;

    tbl[0]  = '{1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b0, 10'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 10'h020, 32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 1'b1, 10'h020, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 1'b0, 10'h020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 10'h013, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[6]  = '{1'b1, 1'b1, 10'h020, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    tbl[7]  = '{1'b1, 1'b0, 10'h020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 10'h030, 32'h0,        4'hF, 32'h0,        1'b1};
    tbl[9]  = '{1'b0, 1'b1, 10'h020, 32'h99999999, 4'h0, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 1'b0, 10'h020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 10'h3FC, 32'h01020304, 4'hF, 32'h0,        1'b0};
    tbl[12] = '{1'b1, 1'b0, 10'h3FC, 32'h0,        4'h0, 32'h01020304, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 10'h022, 32'h77777777, 4'hF, 32'h0,        1'b1};
    tbl[14] = '{1'b1, 1'b0, 10'h020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(m_req_ready), 0);
    chk("reset rsp_valid", 32'(m_rsp_valid), 0);
    chk("reset rdata", m_rdata, 32'h0);
    chk("reset err", 32'(m_err), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release cycle req_ready", 32'(m_req_ready), 0);
    @(posedge clk);
    #1;
    chk("post release req_ready", 32'(m_req_ready), 1);

    for (int i = 0; i < 15; i++) begin
      send(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].xd, tbl[i].xe,
           0, $sformatf("vec%0d", i), acc);
    end

    send(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 5, "backpressure", acc);
    send(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0, "ignored store", acc);

    // A store that has reached RESP survives a reset.
    send(1'b0, 1'b1, 10'h050, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0, "pre store", acc);
    @(negedge clk);
    read = 1'b0; write = 1'b1; addr = 10'h050; wdata = 32'h12121212; byte_en = 4'hF;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("resp store rsp_valid", 32'(m_rsp_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset in resp rsp_valid", 32'(m_rsp_valid), 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    send(1'b1, 1'b0, 10'h050, 32'h0, 4'h0, 32'h12121212, 1'b0, 0, "committed store", acc);

    sel = 2'd3;
    send(1'b0, 1'b1, 10'h040, 32'h12345678, 4'hF, 32'h0, 1'b0, 0, "w3 store", acc);
    send(1'b1, 1'b0, 10'h040, 32'h0, 4'h0, 32'h12345678, 1'b0, 0, "w3 load", acc);
    @(negedge clk);
    read = 1'b0; write = 1'b1; addr = 10'h040; wdata = 32'h5; byte_en = 4'hF; req_valid = 1'b1;
    n = 0;
    while (!m_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("w3 wait rsp_valid", 32'(m_rsp_valid), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("w3 reset rsp_valid", 32'(m_rsp_valid), 0);
    chk("w3 reset req_ready", 32'(m_req_ready), 0);
    chk("w3 reset rdata", m_rdata, 32'h0);
    chk("w3 reset err", 32'(m_err), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("w3 release req_ready", 32'(m_req_ready), 1);
    send(1'b1, 1'b0, 10'h040, 32'h0, 4'h0, 32'h12345678, 1'b0, 0, "w3 discarded store", acc);

    sel = 2'd0;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 1'b1, 10'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, 32'h0, 1'b0, 0, "w0 fill", acc);
    end
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 1'b0, 10'(4 * i), 32'h0, 4'h0, 32'hC0DE0000 + 32'(i), 1'b0, 0,
           $sformatf("w0 load%0d", i), acc);
      if (i > 0) chk($sformatf("w0 period%0d", i), 32'(acc - prev), 2);
      prev = acc;
    end

    chk("scoreboard drained", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
